// File: rtl/alu_pipe_pkg.sv
// Shared types for the alu_pipe datapath.
//
// Contents:
//   NUM_OPS       number of decoded ALU operations (8)
//   MAX_WIDTH     widest operand the payload structs can carry; the top
//                 module stores its WIDTH-bit operands in the low bits
//   op_e          3-bit ALU operation code, OP_ADD..OP_XNOR
//   s1_payload_t  stage-1 register contents {op, err, a, b}
//   s2_payload_t  stage-2 register contents {result, carry, err[, overflow]}
//
// Optional feature: ALU_PIPE_OVERFLOW_EN adds the overflow bit to s2_payload_t.
package alu_pipe_pkg;

    localparam int NUM_OPS   = 8;
    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_OR   = 3'd3,
        OP_AND  = 3'd4,
        OP_NOR  = 3'd5,
        OP_NAND = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    typedef struct packed {
        op_e                  op;
        logic                 err;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } s1_payload_t;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] result;
        logic                 carry;
        logic                 err;
`ifdef ALU_PIPE_OVERFLOW_EN
        logic                 overflow;
`endif
    } s2_payload_t;

endpackage

// File: rtl/alu_pipe_encoder.sv
// Combinational priority encoder for the ALU function code.
//
// The top NUM_OPS bits of func are decoded, MSB first: bit FUNC_W-1 selects
// op 0, bit FUNC_W-2 selects op 1, ... The highest set bit wins. Any bits
// below the decoded range are ignored. With no decoded bit set the op is
// OP_ADD and err is raised.
//
// Ports:
//   func  input  FUNC_W  raw function code (FUNC_W >= 8)
//   op    output op_e    decoded operation
//   err   output 1       no bit set in the decoded range
module alu_pipe_encoder
    import alu_pipe_pkg::*;
#(
    parameter int FUNC_W = 8
) (
    input  logic [FUNC_W-1:0] func,
    output op_e               op,
    output logic              err
);

    // Scan from the lowest-priority bit upwards so the highest set bit is
    // the last one to write op.
    always_comb begin
        op  = OP_ADD;
        err = 1'b1;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (func[FUNC_W-1-i]) begin
                op  = op_e'(i[2:0]);
                err = 1'b0;
            end
        end
    end

    generate
        if (FUNC_W > NUM_OPS) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^func[FUNC_W-NUM_OPS-1:0];
        end
    endgenerate

endmodule

// File: rtl/alu_pipe_datapath.sv
// Two-stage registered ALU pipeline with valid/ready handshakes.
//
// Stage 0 priority-encodes the function code, stage 1 registers the decoded
// op and operands, stage 2 registers the ALU result and flags. The ready
// chain is combinational, so the pipe sustains one transaction per cycle and
// holds at most two under backpressure.
//
// Optional feature: define ALU_PIPE_OVERFLOW_EN to add out_overflow
// (signed two's-complement overflow for ADD/SUB).
//
// Ports:
//   clock        input   1       clock, all state on posedge
//   reset        input   1       synchronous active-high reset
//   in_valid     input   1       input transaction present
//   in_ready     output  1       pipeline can accept this cycle
//   in_func      input   FUNC_W  function code, priority from MSB
//   in_a, in_b   input   WIDTH   operands
//   out_valid    output  1       result present
//   out_ready    input   1       sink accepts result
//   out_result   output  WIDTH   ALU result
//   out_carry    output  1       carry (ADD) / borrow (SUB)
//   out_zero     output  1       out_result == 0
//   out_parity   output  1       parity of out_result (odd if PARITY_ODD)
//   out_error    output  1       function code had no decoded bit set
//   out_overflow output  1       signed overflow (ALU_PIPE_OVERFLOW_EN only)
module alu_pipe_datapath
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FUNC_W     = 8,
    parameter int PARITY_ODD = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic              out_carry,
    output logic              out_zero,
    output logic              out_parity,
    output logic              out_error
`ifdef ALU_PIPE_OVERFLOW_EN
    ,
    output logic              out_overflow
`endif
);

    // WIDTH must lie in 2..MAX_WIDTH so the payload structs can hold it.

    function automatic logic parity_of(input logic [WIDTH-1:0] r);
        return (PARITY_ODD != 0) ? ~(^r) : ^r;
    endfunction

    // Returns {carry, result}; err squashes both to zero.
    function automatic logic [WIDTH:0] alu_eval(input op_e op, input logic err,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] wide;
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_OR:   wide = {1'b0, a | b};
            OP_AND:  wide = {1'b0, a & b};
            OP_NOR:  wide = {1'b0, ~(a | b)};
            OP_NAND: wide = {1'b0, ~(a & b)};
            OP_XNOR: wide = {1'b0, ~(a ^ b)};
            default: wide = '0;
        endcase
        if (err) begin
            wide = '0;
        end
        return wide;
    endfunction

`ifdef ALU_PIPE_OVERFLOW_EN
    function automatic logic overflow_eval(input op_e op, input logic err,
                                           input logic signed [WIDTH-1:0] a,
                                           input logic signed [WIDTH-1:0] b,
                                           input logic signed [WIDTH-1:0] r);
        logic ovf;
        ovf = 1'b0;
        if (!err) begin
            // Overflow iff the result sign disagrees with what the operand
            // signs force: same signs for ADD, opposite signs for SUB.
            if (op == OP_ADD) begin
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end else if (op == OP_SUB) begin
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
        end
        return ovf;
    endfunction
`endif

    // ---------------- stage 0: decode ----------------
    op_e         op_p0;
    logic        err_p0;
    s1_payload_t s1_d_p0;

    alu_pipe_encoder #(
        .FUNC_W (FUNC_W)
    ) u_encoder (
        .func (in_func),
        .op   (op_p0),
        .err  (err_p0)
    );

    always_comb begin
        s1_d_p0               = '0;
        s1_d_p0.op            = op_p0;
        s1_d_p0.err           = err_p0;
        s1_d_p0.a[WIDTH-1:0]  = in_a;
        s1_d_p0.b[WIDTH-1:0]  = in_b;
    end

    // ---------------- handshake ----------------
    logic vld_p1;
    logic vld_p2;
    logic s1_en;
    logic s2_en;

    always_comb begin
        s2_en    = !vld_p2 || out_ready;
        s1_en    = !vld_p1 || s2_en;
        in_ready = s1_en;
    end

    // ---------------- stage 1: operand register ----------------
    s1_payload_t s1_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            s1_p1  <= '0;
        end else if (s1_en) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                s1_p1 <= s1_d_p0;
            end
        end
    end

    // ---------------- ALU on stage-1 contents ----------------
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [WIDTH:0]   alu_p1;
    s2_payload_t      s2_d_p1;

    always_comb begin
        a_p1                  = s1_p1.a[WIDTH-1:0];
        b_p1                  = s1_p1.b[WIDTH-1:0];
        alu_p1                = alu_eval(s1_p1.op, s1_p1.err, a_p1, b_p1);
        s2_d_p1               = '0;
        s2_d_p1.result[WIDTH-1:0] = alu_p1[WIDTH-1:0];
        s2_d_p1.carry         = alu_p1[WIDTH];
        s2_d_p1.err           = s1_p1.err;
`ifdef ALU_PIPE_OVERFLOW_EN
        s2_d_p1.overflow      = overflow_eval(s1_p1.op, s1_p1.err, a_p1, b_p1,
                                              alu_p1[WIDTH-1:0]);
`endif
    end

    // ---------------- stage 2: result register ----------------
    s2_payload_t s2_p2;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            s2_p2  <= '0;
        end else if (s2_en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                s2_p2 <= s2_d_p1;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        out_valid  = vld_p2;
        out_result = s2_p2.result[WIDTH-1:0];
        out_carry  = s2_p2.carry;
        out_error  = s2_p2.err;
        out_zero   = (s2_p2.result[WIDTH-1:0] == '0);
        out_parity = parity_of(s2_p2.result[WIDTH-1:0]);
`ifdef ALU_PIPE_OVERFLOW_EN
        out_overflow = s2_p2.overflow;
`endif
    end

    // Payload bits above WIDTH are constant zero and never consumed.
    logic unused_hi;
    assign unused_hi = ^{s1_p1.a, s1_p1.b, s2_p2.result};

endmodule
